// File: rtl/ls1u_qspi_xip.sv
// ls1u_qspi_xip: read-only XIP QSPI flash controller (0x6B quad-output fast read) on the 8-bit AHB bus
module ls1u_qspi_xip #(
    parameter logic [7:0] CMD     = 8'h6B,
    parameter int         DUMMY   = 8,
    parameter int         CSH_MIN = 2
) (
    input  logic        clk,
    input  logic        hreset_n,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic        hburst,
    input  logic        htrans,
    input  logic [7:0]  hwdata,
    output logic        hready,
    output logic        hresp,
    output logic [7:0]  hrdata,
    output logic        qsel,
    output logic        qsck,
    inout  wire  [3:0]  qspi
);
    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE, S_HOLD, S_CSH
    } state_t;

    state_t      state, nxt;
    logic [6:0]  cnt;
    logic [31:0] sh;
    logic [23:0] addr;
    logic        pend;
    logic [1:0]  err;
    logic        accept, rd_acc, wr_acc, seq, oe;
    wire         unused = ^{hwdata, haddr[31:24]};

    assign accept = hsel & htrans & hready;
    assign rd_acc = accept & ~hwrite;
    assign wr_acc = accept & hwrite;
    assign seq    = hburst & (haddr[23:0] == addr + 24'd1) & (addr != 24'hFFFFFF);
    assign hready = (state == S_IDLE || state == S_DONE || state == S_HOLD) & ~err[0];
    assign hresp  = |err;
    assign qsel   = (state == S_IDLE || state == S_CSH);
    assign qsck   = cnt[0] & (state == S_CMD || state == S_ADDR || state == S_DUMMY || state == S_DATA);
    assign oe     = (state == S_CMD || state == S_ADDR);
    assign qspi[0]   = oe ? sh[31] : 1'bz;
    assign qspi[3:1] = 3'bzzz;

    // Next-state logic; a write in progress keeps HOLD from dropping chip select
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:         nxt = rd_acc ? S_SETUP : S_IDLE;
            S_SETUP:        nxt = S_CMD;
            S_CMD:          nxt = (cnt == 7'd15) ? S_ADDR : S_CMD;
            S_ADDR:         nxt = (cnt == 7'd47) ? S_DUMMY : S_ADDR;
            S_DUMMY:        nxt = (cnt == 7'(2 * DUMMY - 1)) ? S_DATA : S_DUMMY;
            S_DATA:         nxt = (cnt == 7'd3) ? S_DONE : S_DATA;
            S_DONE, S_HOLD: nxt = rd_acc ? (seq ? S_DATA : S_CSH)
                                : (state == S_HOLD && !htrans && !hburst && err == 2'b00) ? S_CSH : S_HOLD;
            S_CSH:          nxt = (cnt == 7'(CSH_MIN - 1)) ? (pend ? S_SETUP : S_IDLE) : S_CSH;
            default:        nxt = S_IDLE;
        endcase
    end

    // State, phase counter, command/address shifter, read data and error response
    always_ff @(posedge clk or negedge hreset_n) begin
        if (!hreset_n) begin
            state  <= S_IDLE;
            cnt    <= 7'd0;
            sh     <= 32'd0;
            addr   <= 24'd0;
            pend   <= 1'b0;
            err    <= 2'b00;
            hrdata <= 8'h00;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? 7'd0 : cnt + 7'd1;
            err   <= {err[0], wr_acc};
            pend  <= rd_acc ? (nxt == S_CSH) : (state == S_CSH && nxt != S_CSH) ? 1'b0 : pend;
            if (rd_acc) begin
                addr <= haddr[23:0];
                sh   <= {CMD, haddr[23:0]};
            end else if (oe && cnt[0]) begin
                sh <= {sh[30:0], 1'b0};
            end
            if (state == S_DATA && cnt[0])
                hrdata <= {hrdata[3:0], qspi};
        end
    end
endmodule

// File: tb/tb_ls1u_qspi_xip.sv
// tb_ls1u_qspi_xip: table-driven bench with a behavioural quad-output flash model
module tb_ls1u_qspi_xip;
    logic        clk = 1'b0, hreset_n = 1'b0, hsel = 1'b0, hwrite = 1'b0, hburst = 1'b0, htrans = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic [7:0]  hwdata = 8'd0;
    logic        hready, hresp, qsel, qsck;
    logic [7:0]  hrdata;
    wire  [3:0]  qspi;
    logic [3:0]  fd = 4'h0;
    logic        foe = 1'b0, tdrv = 1'b0;
    int          ntest = 0, nfail = 0;
    int          nfall = 0, nrise = 0, nb = 0;
    logic [31:0] cap = 32'd0;
    logic        psel = 1'b1, psck = 1'b0;

    assign qspi = foe ? fd : (tdrv ? 4'hA : 4'bzzzz);

    ls1u_qspi_xip dut (
        .clk(clk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
        .hburst(hburst), .htrans(htrans), .hwdata(hwdata), .hready(hready), .hresp(hresp),
        .hrdata(hrdata), .qsel(qsel), .qsck(qsck), .qspi(qspi)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fmem(input logic [23:0] a);
        case (a)
            24'h000010: fmem = 8'hA5;
            24'h000100: fmem = 8'h11;
            24'h000101: fmem = 8'h22;
            24'h000102: fmem = 8'h33;
            default:    fmem = a[7:0] ^ 8'h3C;
        endcase
    endfunction

    // Flash model: captures command/address on rising SCK, drives nibbles after falling SCK
    always @(qsel, qsck) begin
        logic [7:0] b;
        int k;
        if (!qsel && psel) begin nfall++; nb = 0; end
        if (qsel && !psel) foe = 1'b0;
        if (qsck && !psck) begin
            if (nb < 32) cap = {cap[30:0], qspi[0]};
            nb++;
            nrise++;
        end
        if (!qsck && psck && nb >= 40) begin
            k   = nb - 40;
            b   = fmem(cap[23:0] + 24'(k / 2));
            fd  = (k % 2 == 0) ? b[7:4] : b[3:0];
            foe = 1'b1;
        end
        psel = qsel;
        psck = qsck;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h", n, act, exp);
        end
    endtask

    typedef struct {
        logic        w;
        logic [23:0] a;
        logic        b;
        int          gap;
        int          ew;
        logic [7:0]  ed;
        logic        er;
        int          ec;
    } vec_t;

    task automatic xfer(input vec_t v, input int idx);
        int f0 = nfall, r0 = nrise, t = 0, w = 0;
        hsel = 1'b1; htrans = 1'b1; hwrite = v.w; haddr = {8'h00, v.a}; hburst = v.b; hwdata = 8'h5A;
        @(negedge clk);
        while (!hready && t < 200) begin @(negedge clk); t++; end
        chk($sformatf("accept[%0d]", idx), 32'(t < 200), 32'd1);
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 1'b0; hburst = 1'b0; hwrite = 1'b0;
        while (!hready && w < 300) begin @(posedge clk); #1; w++; end
        chk($sformatf("wait[%0d]", idx), 32'(w), 32'(v.ew));
        chk($sformatf("hresp[%0d]", idx), 32'(hresp), 32'(v.er));
        chk($sformatf("cmds[%0d]", idx), 32'(nfall - f0), 32'(v.ec));
        if (!v.w) chk($sformatf("hrdata[%0d]", idx), 32'(hrdata), 32'(v.ed));
        else      chk($sformatf("sck_edges[%0d]", idx), 32'(nrise - r0), 32'd0);
        if (v.ec == 1) chk($sformatf("stream[%0d]", idx), cap, {8'h6B, v.a});
        repeat (v.gap) begin @(posedge clk); #1; end
    endtask

    vec_t vec [12];

    initial begin
        vec[0]  = '{1'b0, 24'h000010, 1'b0, 5, 85, 8'hA5, 1'b0, 1};
        vec[1]  = '{1'b0, 24'h000100, 1'b0, 0, 85, 8'h11, 1'b0, 1};
        vec[2]  = '{1'b0, 24'h000101, 1'b1, 0,  4, 8'h22, 1'b0, 0};
        vec[3]  = '{1'b0, 24'h000102, 1'b1, 0,  4, 8'h33, 1'b0, 0};
        vec[4]  = '{1'b0, 24'h000200, 1'b1, 0, 87, 8'h3C, 1'b0, 1};
        vec[5]  = '{1'b0, 24'h000300, 1'b0, 0, 87, 8'h3C, 1'b0, 1};
        vec[6]  = '{1'b1, 24'h000040, 1'b0, 0,  1, 8'h00, 1'b1, 0};
        vec[7]  = '{1'b0, 24'h000301, 1'b1, 5,  4, 8'h3D, 1'b0, 0};
        vec[8]  = '{1'b0, 24'hFFFFFF, 1'b0, 0, 85, 8'hC3, 1'b0, 1};
        vec[9]  = '{1'b0, 24'h000000, 1'b1, 5, 87, 8'h3C, 1'b0, 1};
        vec[10] = '{1'b1, 24'h000040, 1'b0, 0,  1, 8'h00, 1'b1, 0};
        vec[11] = '{1'b0, 24'h000055, 1'b0, 5, 85, 8'h69, 1'b0, 1};

        repeat (3) @(posedge clk);
        #1;
        tdrv = 1'b1;
        #1;
        chk("reset_qspi_free", 32'(qspi), 32'hA);
        tdrv = 1'b0;
        hreset_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_hready", 32'(hready), 32'd1);
        chk("reset_hresp", 32'(hresp), 32'd0);
        chk("reset_hrdata", 32'(hrdata), 32'h00);
        chk("reset_qsel", 32'(qsel), 32'd1);
        chk("reset_qsck", 32'(qsck), 32'd0);

        for (int i = 0; i < 12; i++) begin
            xfer(vec[i], i);
            if (vec[i].w && i == 10) chk("write_idle_qsel", 32'(qsel), 32'd1);
        end

        hsel = 1'b1; htrans = 1'b1; haddr = 32'h80;
        @(negedge clk);
        chk("midop_ready", 32'(hready), 32'd1);
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("midop_qsel_low", 32'(qsel), 32'd0);
        chk("midop_hready_low", 32'(hready), 32'd0);
        #2 hreset_n = 1'b0;
        #1;
        chk("async_qsel", 32'(qsel), 32'd1);
        chk("async_qsck", 32'(qsck), 32'd0);
        chk("async_hready", 32'(hready), 32'd1);
        tdrv = 1'b1;
        #1;
        chk("async_qspi_free", 32'(qspi), 32'hA);
        tdrv = 1'b0;
        @(posedge clk); #1;
        hreset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_hready", 32'(hready), 32'd1);
        xfer('{1'b0, 24'h000077, 1'b0, 5, 85, 8'h4B, 1'b0, 1}, 12);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule

// File: doc/ls1u_qspi_xip.md
# ls1u_qspi_xip

Read-only execute-in-place QSPI flash controller. It is a slave on the shrinked 8-bit AHB bus driven by CPU_LS1u, downstream of the SoC address decoder. Each bus read is turned into a Fast Read Quad Output (0x6B) transaction on the external flash pins `qsel`/`qsck`/`qspi`. Sequential incrementing reads keep the flash selected and stream further bytes without re-issuing command or address.

## Interface
- `CMD`, 8'h6B: read opcode, sent on `qspi[0]` MSB first.
- `DUMMY`, 8: dummy SCK cycles between address and data.
- `CSH_MIN`, 2: minimum `clk` cycles `qsel` stays high between transactions.

Ports:
- `clk` in 1: single system clock; all logic is on its rising edge.
- `hreset_n` in 1: asynchronous, active-low reset.
- `hsel` in 1: slave select from the decoder.
- `haddr` in 32: byte address; only [23:0] is used.
- `hwrite` in 1: 1 = write, which is unsupported.
- `hburst` in 1: 1 = this transfer continues an incrementing burst.
- `htrans` in 1: 1 = active transfer, 0 = idle.
- `hwdata` in 8: ignored.
- `hready` out 1: transfer complete / ready to accept.
- `hresp` out 1: 1 = error response.
- `hrdata` out 8: read data; valid while `hready`=1 after a read.
- `qsel` out 1: flash chip select, active low.
- `qsck` out 1: flash clock, `clk`/2 while active.
- `qspi` inout 4: IO0..IO3, tristated when not driving.

## Operation
- Accept: a transfer is accepted on a rising edge where `hsel`&`htrans`&`hready` = 1. `haddr[23:0]`, `hwrite` and `hburst` are latched.
- Write accepted:
  - Cycle 1: `hready`=0, `hresp`=1.
  - Cycle 2: `hready`=1, `hresp`=1.
  - Return to the prior state. Flash pins and CS state are untouched.
- FSM states: IDLE, SETUP, CMD, ADDR, DUMMY, DATA, DONE, HOLD, CSH.
- IDLE: `qsel`=1, `hready`=1. A read goes to SETUP.
- SETUP: 1 cycle. `qsel`→0, `qsck`=0.
- CMD: 8 bits of `CMD`, then ADDR: 24 address bits MSB first. Both are driven on `qspi[0]` only; `qspi[3:1]` are tristated.
- Bit timing: each bit takes 2 `clk` cycles. In the low phase, drive the bit with `qsck`=0. In the high phase, `qsck`=1 and the flash samples.
- DUMMY: `DUMMY` SCK periods with all `qspi` tristated.
- DATA: 2 quad nibbles, high nibble first. Each nibble is sampled from `qspi[3:0]` on the `clk` edge that ends the high phase.
- DONE: 1 cycle. `hrdata` = byte, `hready`=1. A new transfer may be accepted in this cycle. Otherwise go to HOLD.
- HOLD: `qsel` stays 0, `qsck`=0, `hready`=1.
  - Accepted read with `hburst`=1 and address = last+1 goes straight to DATA.
  - Any other accepted read, or `htrans`=0 with `hburst`=0, goes to CSH.
- CSH: `qsel`=1 for `CSH_MIN` cycles, `hready`=0.
  - If a read was already accepted, go to SETUP. Otherwise go to IDLE.
- Address wrap: 24'hFFFFFF → 24'h000000 is never treated as sequential. It forces CSH and a full command.
- Address counter: 24 bits, modulo 2^24.

## Timing
- Reset values: `hready`=1, `hresp`=0, `hrdata`=8'h00, `qsel`=1, `qsck`=0, `qspi` all high-Z, FSM = IDLE.
- Reset is asynchronous. Asserting it mid-transaction releases `qsel` and tristates `qspi` immediately, with no bus response.
- New read from IDLE:
  - `hready`=0 for 1 (SETUP) + 16 (CMD) + 48 (ADDR) + 2·`DUMMY` + 4 (DATA) = 85 cycles at defaults.
  - `hready`=1 with data on the 86th cycle after acceptance.
- Sequential read from HOLD: `hready`=0 for 4 cycles, data on the 5th.
- Non-sequential read from HOLD: `CSH_MIN` + 85 wait cycles.
- `qsck` period = 2 `clk`, 50% duty. `qsck` never toggles while `qsel`=1.
- Output-enable of `qspi[0]` is deasserted in the same cycle ADDR ends.

## Test plan
- Single read: reset, then read 0x000010 with flash model byte 0xA5. Required: `qsel` low for exactly the full transaction; serial stream 0x6B, 0x000010; `hrdata`=0xA5 after 85 wait cycles; `hresp`=0.
- Burst: reads 0x100, 0x101, 0x102 with `hburst`=1 on the 2nd and 3rd, flash data 0x11/0x22/0x33. Required: one command only; 2nd and 3rd bytes each after 4 wait cycles; `qsel` low throughout.
- Break: after reading 0x200, read 0x300 with `hburst`=0. Required: `qsel` high ≥2 cycles, then a new command with address 0x000300.
- Wrap: burst read 0xFFFFFF then 0x000000 with `hburst`=1. Required: CS deasserted and a full command re-issued for 0x000000.
- Write: write to 0x40 with `hwdata`=0x5A. Required: two-cycle error (`hresp`=1, `hready` 0 then 1); no `qsck` edges; no `qsel` change.
- Reset mid-op: assert `hreset_n`=0 during ADDR. Required: `qsel`=1 and `qspi`=Z asynchronously, `hready`=1 after release, and the next read completes normally.
